// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// FSM encoding is fixed so other blocks and debug tooling can decode it.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WAIT  = 2'd2,
    STALL = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] sext32(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_sequencer_shift.sv
// Word-offset scaler: multiplies a 32-bit word count by four.
module left_shift_2bits_32 (
  input  logic [31:0] value,
  output logic [31:0] shifted
);

  assign shifted = value << 2;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch controller: owns the PC, runs the fetch handshake,
// resolves branch/jump/register redirects and flushes wrong-path fetches.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic [31:0] redir_pc,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        j_req,
  input  logic [25:0] j_index,
  input  logic        jr_req,
  input  logic [31:0] jr_addr,
  output logic        flush,
  output logic        misalign_err
);

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic        pend_valid, pend_valid_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic        flush_raw;

  logic [31:0] br_sext, br_shift;
  logic [31:0] seq_pc, link_pc, redir_target;
  logic        redir;

  assign br_sext = sext32(br_offset);

  left_shift_2bits_32 u_br_shift (
    .value   (br_sext),
    .shifted (br_shift)
  );

  assign seq_pc  = pc + PC_STEP;
  assign link_pc = redir_pc + PC_STEP;
  assign redir   = jr_req | j_req | br_taken;

  always_comb begin
    redir_target = seq_pc;
    if (jr_req)        redir_target = {jr_addr[31:2], 2'b00};
    else if (j_req)    redir_target = {link_pc[31:28], j_index, 2'b00};
    else if (br_taken) redir_target = link_pc + br_shift;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nxt      = state;
    pc_nxt         = pc;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    fetch_valid    = 1'b0;
    flush_raw      = 1'b0;

    unique case (state)
      IDLE: begin
        state_nxt = RUN;
        if (redir) begin
          pc_nxt    = redir_target;
          flush_raw = 1'b1;
        end
      end

      RUN: begin
        fetch_valid = !stall;
        if (stall) begin
          state_nxt = STALL;
          if (redir) begin
            pc_nxt    = redir_target;
            flush_raw = 1'b1;
          end
        end else if (fetch_ready) begin
          pc_nxt    = redir ? redir_target : seq_pc;
          flush_raw = redir;
        end else begin
          // Request is now outstanding: pc must hold, so a redirect is parked.
          state_nxt = WAIT;
          if (redir) begin
            pend_valid_nxt = 1'b1;
            pend_pc_nxt    = redir_target;
          end
        end
      end

      WAIT: begin
        fetch_valid = 1'b1;
        if (fetch_ready) begin
          state_nxt      = stall ? STALL : RUN;
          pend_valid_nxt = 1'b0;
          if (pend_valid) begin
            pc_nxt    = pend_pc;
            flush_raw = 1'b1;
          end else if (redir) begin
            pc_nxt    = redir_target;
            flush_raw = 1'b1;
          end else begin
            pc_nxt = seq_pc;
          end
        end else if (redir && !pend_valid) begin
          pend_valid_nxt = 1'b1;
          pend_pc_nxt    = redir_target;
        end
      end

      STALL: begin
        if (!stall) state_nxt = RUN;
        if (redir) begin
          pc_nxt    = redir_target;
          flush_raw = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Pulses are qualified by rst_n so every output except pc reads 0 in reset.
  assign flush        = flush_raw & rst_n;
  assign misalign_err = jr_req & (|jr_addr[1:0]) & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= RESET_PC;
    end else begin
      // NOTE: sequential state uses <= so all registers update from the same snapshot.
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_valid <= pend_valid_nxt;
      pend_pc    <= pend_pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        br_taken = 1'b0;
  logic [15:0] br_offset = '0;
  logic        j_req = 1'b0;
  logic [25:0] j_index = '0;
  logic        jr_req = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        flush;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .stall        (stall),
    .redir_pc     (redir_pc),
    .br_taken     (br_taken),
    .br_offset    (br_offset),
    .j_req        (j_req),
    .j_index      (j_index),
    .jr_req       (jr_req),
    .jr_addr      (jr_addr),
    .flush        (flush),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  bit          m_started, m_out, m_blk;
  logic [31:0] m_pend[$];

  task automatic model_reset();
    m_pc = 32'h0; m_started = 0; m_out = 0; m_blk = 0; m_pend.delete();
  endtask

  // Evaluates the current cycle's outputs and advances the model by one clock.
  task automatic model_step(output logic e_fv, output logic e_flush, output logic e_mis);
    logic        rd;
    logic [31:0] t;
    int          off;
    rd  = jr_req | j_req | br_taken;
    off = int'($signed(br_offset));
    if (jr_req)       t = jr_addr & ~32'h3;
    else if (j_req)   t = ((redir_pc + 32'd4) & 32'hF000_0000) | (32'(j_index) * 4);
    else              t = redir_pc + 32'd4 + 32'(off * 4);
    e_mis   = jr_req && (jr_addr % 4 != 0);
    e_fv    = 0;
    e_flush = 0;
    if (!m_started) begin
      m_started = 1;
      if (rd) begin m_pc = t; e_flush = 1; end
    end else if (m_out) begin
      e_fv = 1;
      if (fetch_ready) begin
        if (m_pend.size() > 0) begin m_pc = m_pend[0]; e_flush = 1; end
        else if (rd) begin m_pc = t; e_flush = 1; end
        else m_pc = m_pc + 4;
        m_pend.delete(); m_out = 0; m_blk = stall;
      end else if (rd) m_pend.push_back(t);
    end else if (m_blk) begin
      if (rd) begin m_pc = t; e_flush = 1; end
      m_blk = stall;
    end else begin
      e_fv = !stall;
      if (stall) begin
        m_blk = 1;
        if (rd) begin m_pc = t; e_flush = 1; end
      end else if (fetch_ready) begin
        if (rd) begin m_pc = t; e_flush = 1; end
        else m_pc = m_pc + 4;
      end else begin
        m_out = 1;
        if (rd) m_pend.push_back(t);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_redir();
    br_taken = 0; j_req = 0; jr_req = 0;
    redir_pc = '0; br_offset = '0; j_index = '0; jr_addr = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; jr_req = 1; jr_addr = 32'h3; br_taken = 1;
    #1;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    clear_redir();
    tick();
    rst_n = 1;
    #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL idle_fv: got %b want 0", fetch_valid); end
  endtask

  task automatic test_sequential();
    fetch_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_checks++; if (pc !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 32'(i * 4)); end
      n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv[%0d]: got %b want 1", i, fetch_valid); end
    end
  endtask

  task automatic test_branch();
    tick();
    br_taken = 1; redir_pc = 32'h100; br_offset = 16'hFFFE;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b want 1", flush); end
    tick(); clear_redir(); #1;
    n_checks++; if (pc !== 32'hFC) begin n_fail++; $display("FAIL br_pc: got %h want %h", pc, 32'hFC); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_flush_once: got %b want 0", flush); end
  endtask

  task automatic test_jump();
    tick();
    j_req = 1; redir_pc = 32'h3000_0010; j_index = 26'h40;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL j_flush: got %b want 1", flush); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL j_misalign: got %b want 0", misalign_err); end
    tick(); #1;
    n_checks++; if (pc !== 32'h3000_0100) begin n_fail++; $display("FAIL j_pc: got %h want %h", pc, 32'h3000_0100); end
    jr_req = 1; jr_addr = 32'h2003;
    #1;
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL jr_misalign: got %b want 1", misalign_err); end
    tick(); clear_redir(); #1;
    n_checks++; if (pc !== 32'h2000) begin n_fail++; $display("FAIL jr_pc: got %h want %h", pc, 32'h2000); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL jr_misalign_once: got %b want 0", misalign_err); end
  endtask

  task automatic test_wait_stall();
    tick();
    jr_req = 1; jr_addr = 32'h20;
    tick(); clear_redir();
    fetch_ready = 0; stall = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL wait_pc[%0d]: got %h want %h", k, pc, 32'h20); end
      n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL wait_fv[%0d]: got %b want 1", k, fetch_valid); end
      tick(); stall = (k == 0); #1;
    end
    fetch_ready = 1; stall = 1; #1;
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL wait_ready_fv: got %b want 1", fetch_valid); end
    tick(); #1;
    n_checks++; if (pc !== 32'h24) begin n_fail++; $display("FAIL wait_adv_pc: got %h want %h", pc, 32'h24); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_fv: got %b want 0", fetch_valid); end
    tick(); stall = 0; #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_exit_fv: got %b want 0", fetch_valid); end
    tick(); #1;
    n_checks++; if (fetch_valid !== 1'b1 || pc !== 32'h24) begin n_fail++; $display("FAIL resume: got fv=%b pc=%h want fv=1 pc=%h", fetch_valid, pc, 32'h24); end
  endtask

  task automatic test_pending();
    tick(); fetch_ready = 0; #1;
    tick();
    br_taken = 1; redir_pc = 32'h7C; br_offset = 16'h0; #1;
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL pend_latch_flush: got %b want 0", flush); end
    tick(); clear_redir();
    j_req = 1; redir_pc = 32'h0; j_index = 26'h100; #1;
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL pend_drop_flush: got %b want 0", flush); end
    tick(); clear_redir(); fetch_ready = 1; #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL pend_hs_flush: got %b want 1", flush); end
    n_checks++; if (pc !== 32'h28) begin n_fail++; $display("FAIL pend_hold_pc: got %h want %h", pc, 32'h28); end
    tick(); #1;
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL pend_pc: got %h want %h", pc, 32'h80); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL pend_flush_once: got %b want 0", flush); end
    tick(); #1;
    n_checks++; if (pc !== 32'h84) begin n_fail++; $display("FAIL pend_next: got %h want %h", pc, 32'h84); end
  endtask

  task automatic test_reset_mid_wait();
    tick(); fetch_ready = 0; #1;
    tick(); br_taken = 1; redir_pc = 32'h7C; br_offset = 16'h0; #1;
    tick(); clear_redir(); #1;
    rst_n = 0; #1;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_pc: got %h want %h", pc, 32'h0); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fv: got %b want 0", fetch_valid); end
    tick(); rst_n = 1; fetch_ready = 1; #1;
    tick(); #1;
    n_checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_restart: got pc=%h fv=%b want pc=0 fv=1", pc, fetch_valid); end
    tick(); #1;
    n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL rst_mid_drop: got %h want %h", pc, 32'h4); end
  endtask

  task automatic test_random();
    logic e_fv, e_flush, e_mis;
    logic [31:0] e_pc;
    rst_n = 0; clear_redir(); fetch_ready = 0; stall = 0;
    tick(); rst_n = 1;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      stall       = ($urandom % 4) == 0;
      fetch_ready = ($urandom % 10) < 7;
      br_taken    = ($urandom % 8) == 0;
      j_req       = ($urandom % 12) == 0;
      jr_req      = ($urandom % 14) == 0;
      redir_pc    = $urandom & ~32'h3;
      br_offset   = 16'($urandom);
      j_index     = 26'($urandom);
      jr_addr     = $urandom;
      #1;
      e_pc = m_pc;
      model_step(e_fv, e_flush, e_mis);
      n_checks++; if (pc !== e_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", c, pc, e_pc); end
      n_checks++; if (fetch_valid !== e_fv) begin n_fail++; $display("FAIL rnd_fv[%0d]: got %b want %b", c, fetch_valid, e_fv); end
      n_checks++; if (flush !== e_flush) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", c, flush, e_flush); end
      n_checks++; if (misalign_err !== e_mis) begin n_fail++; $display("FAIL rnd_misalign[%0d]: got %b want %b", c, misalign_err, e_mis); end
      tick();
    end
    clear_redir();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wait_stall();
    test_pending();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
